// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory bus arbiter.
// Line width is derived from word width and words per line.
package mem_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;

    function automatic int line_w(int data_width, int offset_length);
        return data_width * (2 ** offset_length);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache line bus: the master issues commands and lines,
// the slave returns fill data and valid/ready responses.
interface mem_bus_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_W     = 2048
);

    logic                  command_valid;
    logic                  command_store;
    logic                  command_rready;
    logic [ADDR_WIDTH-1:0] command_addr;
    logic [LINE_W-1:0]     data_to_bus;
    logic [LINE_W-1:0]     data_from_bus;
    logic                  bus_valid;
    logic                  bus_ready;

    modport master (
        output command_valid, command_store, command_rready,
        output command_addr, data_to_bus,
        input  data_from_bus, bus_valid, bus_ready
    );

    modport slave (
        input  command_valid, command_store, command_rready,
        input  command_addr, data_to_bus,
        output data_from_bus, bus_valid, bus_ready
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick; on a tie the side that did
// not own the previous transaction wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       pick
);

    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the I-cache (r0) and the D-cache (r1),
// holding the grant per transaction with a watchdog release.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int OFFSET_LENGTH  = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    mem_bus_if.slave   r0,
    mem_bus_if.slave   r1,
    mem_bus_if.master  mem,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int LINE_W = line_w(DATA_WIDTH, OFFSET_LENGTH);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TL = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] T_LAST = TW'(TL);

    arb_state_t    state, state_d;
    logic          owner, owner_d;
    logic          last_grant, last_d;
    logic [TW-1:0] timer, timer_d;
    logic          err_d;
    logic          pick;

    logic                  own_valid, own_store, own_rready;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [LINE_W-1:0]     own_data;
    logic                  done, wdog;

    rr_pick2 u_pick (
        .req        ({r1.command_valid, r0.command_valid}),
        .last_grant (last_grant),
        .pick       (pick)
    );

    assign own_valid  = (owner == 1'(REQ_DCACHE)) ? r1.command_valid  : r0.command_valid;
    assign own_store  = (owner == 1'(REQ_DCACHE)) ? r1.command_store  : r0.command_store;
    assign own_rready = (owner == 1'(REQ_DCACHE)) ? r1.command_rready : r0.command_rready;
    assign own_addr   = (owner == 1'(REQ_DCACHE)) ? r1.command_addr   : r0.command_addr;
    assign own_data   = (owner == 1'(REQ_DCACHE)) ? r1.data_to_bus    : r0.data_to_bus;

    // Only the response matching the command kind ends the transaction.
    assign done = own_store ? mem.bus_ready : mem.bus_valid;
    assign wdog = (TIMEOUT_CYCLES > 0) && (timer == T_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            last_grant  <= last_d;
            timer       <= timer_d;
            timeout_err <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        last_d  = last_grant;
        timer_d = timer;
        err_d   = timeout_err;
        unique case (state)
            IDLE: begin
                if (r0.command_valid || r1.command_valid) begin
                    state_d = BUSY;
                    owner_d = pick;
                    timer_d = '0;
                end
            end
            BUSY: begin
                if (!own_valid || done || wdog) begin
                    state_d = IDLE;
                    last_d  = owner;
                    timer_d = '0;
                    err_d   = timeout_err | (own_valid & ~done & wdog);
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic                  o_valid, o_store, o_rready;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [LINE_W-1:0]     o_data;
    logic [1:0]            o_grant, o_bv, o_br;

    always_comb begin
        o_valid  = 1'b0;
        o_store  = 1'b0;
        o_rready = 1'b0;
        o_addr   = '0;
        o_data   = '0;
        o_grant  = 2'b00;
        o_bv     = 2'b00;
        o_br     = 2'b00;
        if (state == BUSY) begin
            o_valid        = own_valid;
            o_store        = own_store;
            o_rready       = own_rready;
            o_addr         = own_addr;
            o_data         = own_data;
            o_grant[owner] = 1'b1;
            o_bv[owner]    = mem.bus_valid;
            o_br[owner]    = mem.bus_ready;
        end
    end

    assign mem.command_valid  = o_valid;
    assign mem.command_store  = o_store;
    assign mem.command_rready = o_rready;
    assign mem.command_addr   = o_addr;
    assign mem.data_to_bus    = o_data;
    assign grant              = o_grant;

    assign r0.bus_valid     = o_bv[REQ_ICACHE];
    assign r1.bus_valid     = o_bv[REQ_DCACHE];
    assign r0.bus_ready     = o_br[REQ_ICACHE];
    assign r1.bus_ready     = o_br[REQ_DCACHE];
    assign r0.data_from_bus = mem.data_from_bus;
    assign r1.data_from_bus = mem.data_from_bus;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: grant scoreboard plus directed
// checks of latency, round robin, store, watchdog, reset and abort.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int OL = 5;
    localparam int LW = line_w(DW, OL);
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout_err;

    mem_bus_if #(.ADDR_WIDTH(AW), .LINE_W(LW)) r0_if ();
    mem_bus_if #(.ADDR_WIDTH(AW), .LINE_W(LW)) r1_if ();
    mem_bus_if #(.ADDR_WIDTH(AW), .LINE_W(LW)) mem_if ();

    mem_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .OFFSET_LENGTH  (OL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .r0          (r0_if),
        .r1          (r1_if),
        .mem         (mem_if),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  g;
        logic [63:0] addr;
        logic        st;
    } exp_t;

    exp_t sb[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every new grant must match the oldest outstanding request.
    logic [1:0] prev_g = 2'b00;
    always @(negedge clk) begin : mon
        exp_t e;
        if (grant != 2'b00 && prev_g == 2'b00) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_grant", 64'(grant), 64'(e.g));
                chk("sb_addr", mem_if.command_addr, e.addr);
                chk("sb_store", 64'(mem_if.command_store), 64'(e.st));
            end
        end
        prev_g = grant;
    end

    task automatic drive(int ch, bit v, bit st, logic [63:0] a, logic [LW-1:0] d);
        if (ch == 0) begin
            r0_if.command_valid  = v;
            r0_if.command_store  = st;
            r0_if.command_rready = v & ~st;
            r0_if.command_addr   = a;
            r0_if.data_to_bus    = d;
        end else begin
            r1_if.command_valid  = v;
            r1_if.command_store  = st;
            r1_if.command_rready = v & ~st;
            r1_if.command_addr   = a;
            r1_if.data_to_bus    = d;
        end
    endtask

    task automatic req(int ch, bit st, logic [63:0] a, logic [LW-1:0] d);
        exp_t e;
        e.g    = (ch == 0) ? 2'b01 : 2'b10;
        e.addr = a;
        e.st   = st;
        sb.push_back(e);
        drive(ch, 1'b1, st, a, d);
    endtask

    task automatic drop(int ch);
        drive(ch, 1'b0, 1'b0, 64'd0, '0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic gchk(string tag, logic [1:0] g);
        @(negedge clk);
        chk(tag, 64'(grant), 64'(g));
    endtask

    // Memory answers a fill in the current cycle; returns one cycle later.
    task automatic fill_resp(int ch, logic [LW-1:0] d);
        mem_if.bus_valid     = 1'b1;
        mem_if.data_from_bus = d;
        @(negedge clk);
        chk("resp_own", 64'(ch == 1 ? r1_if.bus_valid : r0_if.bus_valid), 64'd1);
        chk("resp_other", 64'(ch == 1 ? r0_if.bus_valid : r1_if.bus_valid), 64'd0);
        chk("bcast", 64'(r0_if.data_from_bus == d && r1_if.data_from_bus == d), 64'd1);
        tick();
        mem_if.bus_valid = 1'b0;
        drop(ch);
    endtask

    logic [LW-1:0] line_a5;
    logic [LW-1:0] rnd;
    int            n;

    initial begin
        line_a5 = {(LW / 8){8'hA5}};
        for (int i = 0; i < LW / 32; i++) rnd[i*32 +: 32] = $urandom;
        drop(0);
        drop(1);
        mem_if.data_from_bus = '0;
        mem_if.bus_valid     = 1'b0;
        mem_if.bus_ready     = 1'b0;

        #12;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_valid", 64'(mem_if.command_valid), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Responses while idle reach nobody.
        mem_if.bus_valid = 1'b1;
        mem_if.bus_ready = 1'b1;
        @(negedge clk);
        chk("idle_bv", 64'({r1_if.bus_valid, r0_if.bus_valid}), 64'd0);
        chk("idle_br", 64'({r1_if.bus_ready, r0_if.bus_ready}), 64'd0);
        tick();
        mem_if.bus_valid = 1'b0;
        mem_if.bus_ready = 1'b0;

        // Single fill from r0.
        req(0, 1'b0, 64'h1000, '0);
        @(negedge clk);
        chk("t1_nocomb_valid", 64'(mem_if.command_valid), 64'd0);
        chk("t1_nocomb_grant", 64'(grant), 64'd0);
        tick();
        gchk("t1_grant", 2'b01);
        chk("t1_valid", 64'(mem_if.command_valid), 64'd1);
        chk("t1_rready", 64'(mem_if.command_rready), 64'd1);
        tick();
        tick();
        tick();
        fill_resp(0, rnd);
        gchk("t1_idle", 2'b00);
        chk("t1_idle_valid", 64'(mem_if.command_valid), 64'd0);
        tick();

        // Simultaneous requests from reset, then alternation.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req(0, 1'b0, 64'h3000, '0);
        req(1, 1'b0, 64'h4000, '0);
        gchk("t2_pre", 2'b00);
        tick();
        gchk("t2_first", 2'b01);
        tick();
        fill_resp(0, rnd);
        gchk("t2_turn", 2'b00);
        tick();
        gchk("t2_second", 2'b10);
        tick();
        fill_resp(1, ~rnd);
        req(0, 1'b0, 64'h5000, '0);
        req(1, 1'b0, 64'h6000, '0);
        gchk("t2_turn2", 2'b00);
        tick();
        gchk("t2_alt", 2'b01);
        tick();
        fill_resp(0, rnd);
        gchk("t2_turn3", 2'b00);
        tick();
        gchk("t2_r1_again", 2'b10);
        tick();
        fill_resp(1, rnd);
        tick();

        // Store from r1 with a stray fill-valid pulse.
        req(1, 1'b1, 64'h2040, line_a5);
        @(negedge clk);
        tick();
        gchk("t3_grant", 2'b10);
        chk("t3_store", 64'(mem_if.command_store), 64'd1);
        chk("t3_wdata", 64'(mem_if.data_to_bus == line_a5), 64'd1);
        tick();
        mem_if.bus_valid = 1'b1;
        @(negedge clk);
        chk("t3_fwd_bv", 64'(r1_if.bus_valid), 64'd1);
        chk("t3_no_br", 64'(r1_if.bus_ready), 64'd0);
        tick();
        mem_if.bus_valid = 1'b0;
        mem_if.bus_ready = 1'b1;
        gchk("t3_still_busy", 2'b10);
        chk("t3_br", 64'(r1_if.bus_ready), 64'd1);
        chk("t3_br_other", 64'(r0_if.bus_ready), 64'd0);
        tick();
        mem_if.bus_ready = 1'b0;
        drop(1);
        gchk("t3_idle", 2'b00);
        chk("t3_br_once", 64'(r1_if.bus_ready), 64'd0);
        tick();

        // Watchdog: memory never answers r0.
        req(0, 1'b0, 64'h7000, '0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant == 2'b01) n++;
            else if (n > 0) break;
        end
        chk("t4_busy_cycles", 64'(n), 64'd8);
        chk("t4_err", 64'(timeout_err), 64'd1);
        chk("t4_idle", 64'(grant), 64'd0);
        drop(0);
        req(1, 1'b0, 64'h8000, '0);
        gchk("t4_r1", 2'b10);
        tick();
        fill_resp(1, rnd);
        @(negedge clk);
        chk("t4_err_sticky", 64'(timeout_err), 64'd1);
        tick();

        // Reset in the middle of a transaction.
        req(0, 1'b0, 64'h9000, '0);
        @(negedge clk);
        tick();
        gchk("t5_grant", 2'b01);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(mem_if.command_valid), 64'd0);
        chk("t5_async_grant", 64'(grant), 64'd0);
        chk("t5_err_clr", 64'(timeout_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req(0, 1'b0, 64'hA000, '0);
        req(1, 1'b0, 64'hB000, '0);
        gchk("t5_r0_first", 2'b01);
        tick();
        fill_resp(0, rnd);
        gchk("t5_turn", 2'b00);
        tick();
        gchk("t5_r1", 2'b10);
        tick();
        fill_resp(1, rnd);
        tick();

        // r0 aborts with r1 pending.
        req(0, 1'b0, 64'hC000, '0);
        @(negedge clk);
        tick();
        gchk("t6_grant", 2'b01);
        tick();
        req(1, 1'b0, 64'hD000, '0);
        tick();
        drop(0);
        gchk("t6_abort_cycle", 2'b01);
        chk("t6_fwd_valid", 64'(mem_if.command_valid), 64'd0);
        tick();
        gchk("t6_idle", 2'b00);
        tick();
        gchk("t6_r1", 2'b10);
        chk("t6_no_err", 64'(timeout_err), 64'd0);
        tick();
        fill_resp(1, rnd);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between two cache requesters: requester 0 is the instruction cache and requester 1 is the data cache.
- Each requester side uses the existing cache bus signalling (command_valid / store / rready / addr / line data, with bus_valid / bus_ready responses).
- Grants one requester per transaction using round-robin.
- Holds the grant until the transaction completes, forwards responses only to the owner, and releases the bus on a watchdog timeout.

Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, word width.
- OFFSET_LENGTH, 5, log2 of words per line; LINE_W = DATA_WIDTH*(2**OFFSET_LENGTH).
- TIMEOUT_CYCLES, 1024, maximum cycles in BUSY before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_command_valid, r1_command_valid  in  1  requester holds the request high until it is served.
- r0_command_store, r1_command_store  in  1  1 = line writeback, 0 = line fill.
- r0_command_rready, r1_command_rready  in  1  requester is ready to accept fill data.
- r0_command_addr, r1_command_addr  in  ADDR_WIDTH  line-aligned address.
- r0_data_to_bus, r1_data_to_bus  in  LINE_W  writeback line.
- r0_data_from_bus, r1_data_from_bus  out  LINE_W  fill data.
- r0_bus_valid, r1_bus_valid  out  1  fill-data-valid, routed to owner only.
- r0_bus_ready, r1_bus_ready  out  1  store accepted, routed to owner only.
- mem_command_valid, mem_command_store, mem_command_rready  out  1  forwarded command.
- mem_command_addr  out  ADDR_WIDTH  forwarded address.
- mem_data_to_bus  out  LINE_W  forwarded writeback line.
- mem_data_from_bus  in  LINE_W  fill data from memory.
- mem_bus_valid, mem_bus_ready  in  1  memory responses.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  sticky flag; set when the watchdog fires.

Behaviour:
- State machine (arb_state_t): IDLE and BUSY.
- Registers:
  - owner (1 bit).
  - last_grant (1 bit).
  - timer (width $clog2(TIMEOUT_CYCLES+1)).
  - timeout_err.
- Reset (async, reset=0):
  - state=IDLE, owner=0, last_grant=1 (so requester 0 wins the first tie), timer=0, timeout_err=0.
  - All outputs read 0 while in IDLE.
- IDLE:
  - All mem_command_* = 0, grant = 00, all r*_bus_valid/ready = 0.
  - Exactly one rN_command_valid is high: owner <= N, go to BUSY.
  - Both are high: owner <= ~last_grant, go to BUSY.
  - Neither is high: stay in IDLE.
- Latency:
  - Request sampled in cycle T; grant and mem_command_valid are asserted in T+1.
  - There is no combinational path from r*_command_valid to mem_command_valid.
- BUSY:
  - mem_command_{valid,store,rready,addr} and mem_data_to_bus = owner's inputs, combinationally.
  - grant[owner] = 1.
  - rOwner_bus_valid = mem_bus_valid and rOwner_bus_ready = mem_bus_ready, combinationally.
  - The non-owner's bus_valid/bus_ready = 0.
- mem_data_from_bus is broadcast to both r*_data_from_bus at all times; it is qualified only by bus_valid.
- Completion, evaluated in BUSY:
  - Owner store = 1 and mem_bus_ready = 1: complete.
  - Owner store = 0 and mem_bus_valid = 1: complete.
  - The opposite response in the same cycle is ignored for completion but is still forwarded.
  - On completion: last_grant <= owner, timer <= 0, state <= IDLE.
  - Next grant is no earlier than completion cycle + 2, which gives one idle turnaround cycle.
- Abort: owner's command_valid low while in BUSY: treated as an abort; state <= IDLE, last_grant <= owner, no error.
- Watchdog (TIMEOUT_CYCLES > 0):
  - timer increments on each BUSY cycle without completion.
  - When timer reaches TIMEOUT_CYCLES-1 with no completion in that cycle: timeout_err <= 1, state <= IDLE, last_grant <= owner.
  - timeout_err clears only on reset.
- Non-owner requests during BUSY are held pending; they are not dropped.
- Reset asserted mid-BUSY: immediate return to reset values; mem_command_valid falls asynchronously.

Decomposition:
- Package mem_bus_pkg:
  - function line_w(DATA_WIDTH, OFFSET_LENGTH).
  - arb_state_t enum {IDLE, BUSY}.
  - localparams REQ_ICACHE = 0 and REQ_DCACHE = 1.
- Sub-module rr_pick2: combinational; inputs req[1:0] and last_grant; output pick; used in IDLE only.
- Everything else (registers, muxing, timer) stays in mem_bus_arbiter.

Test Plan:
- Only r0 requests a fill at 0x1000, and memory asserts mem_bus_valid 3 cycles after grant:
  - grant = 01 one cycle after request.
  - mem_command_addr = 0x1000, rready = 1.
  - r0_bus_valid pulses, r1_bus_valid stays 0.
  - IDLE follows on the next cycle.
- r0 and r1 both request from reset:
  - r0 is served first.
  - r1 is granted in the second cycle after r0 completes.
  - After a further simultaneous request, r0 is granted in the second cycle after r1 completes (alternation).
- r1 requests a store of 0x2040 with data line = all 0xA5 bytes, memory asserts mem_bus_ready after 2 cycles:
  - mem_command_store = 1 and mem_data_to_bus matches the line.
  - r1_bus_ready pulses once.
  - A concurrent mem_bus_valid pulse during the store does not complete the transaction.
- TIMEOUT_CYCLES = 8, r0 requests, memory never responds:
  - Exactly 8 BUSY cycles, then timeout_err = 1 and IDLE.
  - A subsequent r1 request is granted normally, and timeout_err stays 1.
- reset driven low 2 cycles into BUSY:
  - mem_command_valid and grant drop to 0 asynchronously.
  - After reset releases, a simultaneous request grants r0.
- r0 deasserts command_valid mid-BUSY with r1 pending:
  - r0's transaction is aborted with no timeout_err.
  - r1 is granted two cycles after the abort.
